// File: rtl/lsu_mem_port_pkg.sv
// lsu_mem_port_pkg: shared definitions for the load/store unit.
//   - MEM_ACCESS_TYPE_* encodings and their width. The decoder uses the same encodings.
//   - FSM state codes for lsu_mem_port.
//   - Byte-strobe constants.
//   - Helpers that classify an access type.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (see lsu_mem_port.sv).
package lsu_mem_port_pkg;

  localparam int MEM_ACCESS_TYPE_W = 3;

  localparam logic [MEM_ACCESS_TYPE_W-1:0] MEM_ACCESS_TYPE_NONE = 3'd0;
  localparam logic [MEM_ACCESS_TYPE_W-1:0] MEM_ACCESS_TYPE_RD_B = 3'd1;
  localparam logic [MEM_ACCESS_TYPE_W-1:0] MEM_ACCESS_TYPE_RD_H = 3'd2;
  localparam logic [MEM_ACCESS_TYPE_W-1:0] MEM_ACCESS_TYPE_RD_W = 3'd3;
  localparam logic [MEM_ACCESS_TYPE_W-1:0] MEM_ACCESS_TYPE_WR_B = 3'd4;
  localparam logic [MEM_ACCESS_TYPE_W-1:0] MEM_ACCESS_TYPE_WR_H = 3'd5;
  localparam logic [MEM_ACCESS_TYPE_W-1:0] MEM_ACCESS_TYPE_WR_W = 3'd6;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  function automatic logic is_load(input logic [MEM_ACCESS_TYPE_W-1:0] t);
    return (t == MEM_ACCESS_TYPE_RD_B) || (t == MEM_ACCESS_TYPE_RD_H) ||
           (t == MEM_ACCESS_TYPE_RD_W);
  endfunction

  function automatic logic is_store(input logic [MEM_ACCESS_TYPE_W-1:0] t);
    return (t == MEM_ACCESS_TYPE_WR_B) || (t == MEM_ACCESS_TYPE_WR_H) ||
           (t == MEM_ACCESS_TYPE_WR_W);
  endfunction

  // Halves need an even address; words need a 4-byte-aligned address.
  function automatic logic is_misaligned(input logic [MEM_ACCESS_TYPE_W-1:0] t,
                                         input logic [1:0] off);
    logic half, word;
    half = (t == MEM_ACCESS_TYPE_RD_H) || (t == MEM_ACCESS_TYPE_WR_H);
    word = (t == MEM_ACCESS_TYPE_RD_W) || (t == MEM_ACCESS_TYPE_WR_W);
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// lsu_lane_align: purely combinational lane steering for lsu_mem_port.
// Store side:
//   - st_data is replicated across the lanes of the access size.
//   - st_strb marks the byte lanes being written.
// Load side:
//   - selects the addressed byte or half of ld_data.
//   - zero- or sign-extends it into ld_data_ext.
// Alignment:
//   - Halves use off[1] only and words ignore off.
//   - A misaligned access is therefore steered to its natural alignment.
// Ports:
//   acc_type, off, sign_ext  access type, byte offset addr[1:0], sign-extension flag
//   st_data -> st_data_rep   store data, replicated
//   st_strb                  byte strobes; zero for loads
//   ld_data -> ld_data_ext   raw bus read word -> extended load result
module lsu_lane_align
  import lsu_mem_port_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TYPE_W = MEM_ACCESS_TYPE_W
) (
  input  logic [TYPE_W-1:0] acc_type,
  input  logic [1:0]        off,
  input  logic              sign_ext,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN-1:0]   st_data_rep,
  output logic [3:0]        st_strb,
  input  logic [XLEN-1:0]   ld_data,
  output logic [XLEN-1:0]   ld_data_ext
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte     = ld_data[{off, 3'b000} +: 8];
    ld_half     = ld_data[{off[1], 4'b0000} +: 16];
    st_data_rep = st_data;
    st_strb     = STRB_NONE;
    ld_data_ext = ld_data;
    case (acc_type)
      MEM_ACCESS_TYPE_RD_B: ld_data_ext = {{(XLEN-8){sign_ext & ld_byte[7]}}, ld_byte};
      MEM_ACCESS_TYPE_RD_H: ld_data_ext = {{(XLEN-16){sign_ext & ld_half[15]}}, ld_half};
      MEM_ACCESS_TYPE_WR_B: begin
        st_data_rep = {(XLEN/8){st_data[7:0]}};
        st_strb     = STRB_BYTE << off;
      end
      MEM_ACCESS_TYPE_WR_H: begin
        st_data_rep = {(XLEN/16){st_data[15:0]}};
        st_strb     = STRB_HALF << {off[1], 1'b0};
      end
      MEM_ACCESS_TYPE_WR_W: st_strb = STRB_WORD;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit between the execute stage and data memory.
// Operation:
//   - Accepts one decoded access while IDLE.
//   - Runs one word-aligned request/response transaction: IDLE -> REQ -> RSP -> DONE.
//   - Stalls the core while the transaction is in flight.
//   - Pulses ls_done for one cycle at completion.
//   - Returns the extended load result with its destination register.
// Optional feature macro:
//   - LSU_MISALIGN_TRAP_EN defined: a misaligned access skips the bus. It completes
//     one cycle after accept with ls_err=1.
//   - Macro undefined: ls_err is tied 0 and the access is naturally aligned.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ls_*  (inputs)             execute-stage access: valid, type, sign, addr, wdata, rd
//   ls_stall                   hold pipeline (combinational)
//   ls_done/ls_rdata/ls_wb_rd  completion pulse, load result, destination register
//   ls_wb_en, ls_err           write-back enable, misalign error (qualified by ls_done)
//   bus_*                      data-memory request (req/we/addr/wstrb/wdata) and
//                              response (gnt/rvalid/rdata)
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int TYPE_W  = MEM_ACCESS_TYPE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ls_valid,
  input  logic [TYPE_W-1:0]  ls_type,
  input  logic               ls_sign_ext,
  input  logic [XLEN-1:0]    ls_addr,
  input  logic [XLEN-1:0]    ls_wdata,
  input  logic [RADDR_W-1:0] ls_rd,
  output logic               ls_stall,
  output logic               ls_done,
  output logic [XLEN-1:0]    ls_rdata,
  output logic [RADDR_W-1:0] ls_wb_rd,
  output logic               ls_wb_en,
  output logic               ls_err,
  output logic               bus_req,
  output logic               bus_we,
  output logic [XLEN-1:0]    bus_addr,
  output logic [3:0]         bus_wstrb,
  output logic [XLEN-1:0]    bus_wdata,
  input  logic               bus_gnt,
  input  logic               bus_rvalid,
  input  logic [XLEN-1:0]    bus_rdata
);

  lsu_state_e         state_q, state_d;
  logic [TYPE_W-1:0]  type_q, type_d;
  logic               sign_q, sign_d;
  logic [1:0]         off_q, off_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [XLEN-1:0]    bus_addr_q, bus_addr_d;
  logic [3:0]         bus_wstrb_q, bus_wstrb_d;
  logic [XLEN-1:0]    bus_wdata_q, bus_wdata_d;
  logic               ls_done_q, ls_done_d;
  logic [XLEN-1:0]    ls_rdata_q, ls_rdata_d;
  logic [RADDR_W-1:0] ls_wb_rd_q, ls_wb_rd_d;
  logic               ls_wb_en_q, ls_wb_en_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic               ls_err_q, ls_err_d;
`endif

  logic               accept;
  logic [TYPE_W-1:0]  al_type;
  logic [1:0]         al_off;
  logic               al_sign;
  logic [XLEN-1:0]    al_wdata;
  logic [3:0]         al_strb;
  logic [XLEN-1:0]    al_rdata;

  assign accept = ls_valid && (ls_type != MEM_ACCESS_TYPE_NONE);

  // The single aligner serves two phases that never overlap. In IDLE it shapes
  // the incoming store. Afterwards it extracts the load lane using the captured
  // access attributes.
  always_comb begin
    if (state_q == LSU_IDLE) begin
      al_type = ls_type;
      al_off  = ls_addr[1:0];
      al_sign = ls_sign_ext;
    end else begin
      al_type = type_q;
      al_off  = off_q;
      al_sign = sign_q;
    end
  end

  lsu_lane_align #(.XLEN(XLEN), .TYPE_W(TYPE_W)) u_align (
    .acc_type    (al_type),
    .off         (al_off),
    .sign_ext    (al_sign),
    .st_data     (ls_wdata),
    .st_data_rep (al_wdata),
    .st_strb     (al_strb),
    .ld_data     (bus_rdata),
    .ld_data_ext (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    sign_d      = sign_q;
    off_d       = off_q;
    rd_d        = rd_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    ls_rdata_d  = ls_rdata_q;
    ls_wb_rd_d  = ls_wb_rd_q;
    // Completion qualifiers are single-cycle pulses.
    ls_done_d   = 1'b0;
    ls_wb_en_d  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    ls_err_d    = 1'b0;
`endif
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          type_d      = ls_type;
          sign_d      = ls_sign_ext;
          off_d       = ls_addr[1:0];
          rd_d        = ls_rd;
          bus_we_d    = is_store(ls_type);
          bus_addr_d  = {ls_addr[XLEN-1:2], 2'b00};
          bus_wstrb_d = al_strb;
          bus_wdata_d = al_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
          if (is_misaligned(ls_type, ls_addr[1:0])) begin
            // Trap without touching the bus.
            state_d    = LSU_DONE;
            ls_done_d  = 1'b1;
            ls_err_d   = 1'b1;
            ls_wb_rd_d = ls_rd;
          end else begin
            state_d   = LSU_REQ;
            bus_req_d = 1'b1;
          end
`else
          state_d   = LSU_REQ;
          bus_req_d = 1'b1;
`endif
        end
      end
      LSU_REQ: begin
        if (bus_gnt) begin
          bus_req_d = 1'b0;
          state_d   = LSU_RSP;
        end
      end
      LSU_RSP: begin
        // rvalid is honoured only here, so stale responses are dropped.
        if (bus_rvalid) begin
          state_d    = LSU_DONE;
          ls_done_d  = 1'b1;
          ls_wb_en_d = is_load(type_q);
          ls_wb_rd_d = rd_q;
          if (is_load(type_q)) ls_rdata_d = al_rdata;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      type_q      <= '0;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
      rd_q        <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= STRB_NONE;
      bus_wdata_q <= '0;
      ls_done_q   <= 1'b0;
      ls_rdata_q  <= '0;
      ls_wb_rd_q  <= '0;
      ls_wb_en_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      ls_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      ls_done_q   <= ls_done_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_wb_rd_q  <= ls_wb_rd_d;
      ls_wb_en_q  <= ls_wb_en_d;
`ifdef LSU_MISALIGN_TRAP_EN
      ls_err_q    <= ls_err_d;
`endif
    end
  end

  assign ls_stall  = ((state_q == LSU_IDLE) && accept) ||
                     (state_q == LSU_REQ) || (state_q == LSU_RSP);
  assign ls_done   = ls_done_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_wb_rd  = ls_wb_rd_q;
  assign ls_wb_en  = ls_wb_en_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign ls_err    = ls_err_q;
`else
  assign ls_err    = 1'b0;
`endif
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed, table-driven bench for lsu_mem_port.
// Each table entry is one access with hand-computed bus fields and results.
// Hand-written sequences cover:
//   - bus backpressure;
//   - ls_valid with type NONE and ls_valid during DONE;
//   - reset mid-transaction followed by a stale response.
module tb_lsu_mem_port;

  localparam logic [2:0] T_NONE = 3'd0, T_RDB = 3'd1, T_RDH = 3'd2, T_RDW = 3'd3,
                         T_WRB  = 3'd4, T_WRH = 3'd5, T_WRW = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls_valid;
  logic [2:0]  ls_type;
  logic        ls_sign_ext;
  logic [31:0] ls_addr, ls_wdata;
  logic [4:0]  ls_rd;
  logic        ls_stall, ls_done, ls_wb_en, ls_err;
  logic [31:0] ls_rdata;
  logic [4:0]  ls_wb_rd;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [2:0]  typ;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  lsu_mem_port dut (
    .clk(clk), .rst_n(rst_n),
    .ls_valid(ls_valid), .ls_type(ls_type), .ls_sign_ext(ls_sign_ext),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rd(ls_rd),
    .ls_stall(ls_stall), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .ls_wb_rd(ls_wb_rd), .ls_wb_en(ls_wb_en), .ls_err(ls_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [2:0] t, input logic s,
                              input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                              input logic [31:0] rdat, input logic [31:0] ea,
                              input logic [3:0] es, input logic [31:0] ewd,
                              input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.name = nm; v.typ = t; v.sgn = s; v.addr = a; v.wdata = wd; v.rd = rd;
    v.rdata = rdat; v.e_addr = ea; v.e_strb = es; v.e_wdata = ewd;
    v.e_rdata = erd; v.e_err = eerr;
    return v;
  endfunction

  // One access with gnt after gnt_dly stall cycles and rvalid rsp_dly cycles after gnt.
  // When poke_done is set, a new access is presented during DONE and must be ignored.
  task automatic run(input vec_t v, input int gnt_dly, input int rsp_dly, input bit poke_done);
    logic is_ld, is_st;
    is_ld = (v.typ == T_RDB) || (v.typ == T_RDH) || (v.typ == T_RDW);
    is_st = (v.typ == T_WRB) || (v.typ == T_WRH) || (v.typ == T_WRW);
    ls_valid = 1'b1; ls_type = v.typ; ls_sign_ext = v.sgn; ls_addr = v.addr;
    ls_wdata = v.wdata; ls_rd = v.rd; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    #1 chk({v.name, " stall@accept"}, 32'(ls_stall), 32'd1);
    tick();
    ls_valid = 1'b0; ls_type = T_NONE;
    #1;
    if (v.e_err) begin
      chk({v.name, " trap bus_req"}, 32'(bus_req), 32'd0);
      chk({v.name, " trap done"}, 32'(ls_done), 32'd1);
      chk({v.name, " trap err"}, 32'(ls_err), 32'd1);
      chk({v.name, " trap wb_en"}, 32'(ls_wb_en), 32'd0);
      chk({v.name, " trap stall"}, 32'(ls_stall), 32'd0);
      tick();
      chk({v.name, " trap done clr"}, 32'(ls_done), 32'd0);
      return;
    end
    for (int k = 0; k <= gnt_dly; k++) begin
      chk({v.name, " req"}, 32'(bus_req), 32'd1);
      chk({v.name, " addr"}, bus_addr, v.e_addr);
      chk({v.name, " we"}, 32'(bus_we), 32'(is_st));
      chk({v.name, " wstrb"}, 32'(bus_wstrb), 32'(v.e_strb));
      if (is_st) chk({v.name, " wdata"}, bus_wdata, v.e_wdata);
      chk({v.name, " stall@req"}, 32'(ls_stall), 32'd1);
      chk({v.name, " done@req"}, 32'(ls_done), 32'd0);
      bus_gnt = (k == gnt_dly);
      tick();
    end
    bus_gnt = 1'b0;
    for (int k = 1; k <= rsp_dly; k++) begin
      #1;
      chk({v.name, " req@rsp"}, 32'(bus_req), 32'd0);
      chk({v.name, " stall@rsp"}, 32'(ls_stall), 32'd1);
      chk({v.name, " done@rsp"}, 32'(ls_done), 32'd0);
      bus_rvalid = (k == rsp_dly);
      bus_rdata  = (k == rsp_dly) ? v.rdata : 32'h5A5A_0000 + 32'(k);
      tick();
    end
    bus_rvalid = 1'b0;
    bus_rdata  = 32'hDEAD_BEEF;
    #1;
    chk({v.name, " done"}, 32'(ls_done), 32'd1);
    chk({v.name, " stall@done"}, 32'(ls_stall), 32'd0);
    chk({v.name, " wb_en"}, 32'(ls_wb_en), 32'(is_ld));
    chk({v.name, " err"}, 32'(ls_err), 32'd0);
    chk({v.name, " wb_rd"}, 32'(ls_wb_rd), 32'(v.rd));
    if (is_ld) chk({v.name, " rdata"}, ls_rdata, v.e_rdata);
    if (poke_done) begin
      ls_valid = 1'b1; ls_type = T_RDW; ls_addr = 32'h0000_9000; ls_rd = 5'd31;
      #1 chk({v.name, " stall ignores valid@done"}, 32'(ls_stall), 32'd0);
    end
    tick();
    ls_valid = 1'b0; ls_type = T_NONE;
    #1;
    chk({v.name, " done pulse"}, 32'(ls_done), 32'd0);
    chk({v.name, " wb_en clr"}, 32'(ls_wb_en), 32'd0);
    chk({v.name, " req idle"}, 32'(bus_req), 32'd0);
    if (is_ld) chk({v.name, " rdata hold"}, ls_rdata, v.e_rdata);
  endtask

  initial begin
    // name typ sgn addr wdata rd rdata | exp addr strb wdata rdata err
    tbl.push_back(mk("SB", T_WRB, 0, 32'h1003, 32'h0000_00A5, 5'd1, 32'h0,
                     32'h1000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0));
    tbl.push_back(mk("LB", T_RDB, 1, 32'h2002, 32'h0, 5'd5, 32'h12F0_3456,
                     32'h2000, 4'b0000, 32'h0, 32'hFFFF_FFF0, 0));
    tbl.push_back(mk("LBU", T_RDB, 0, 32'h2002, 32'h0, 5'd7, 32'h12F0_3456,
                     32'h2000, 4'b0000, 32'h0, 32'h0000_00F0, 0));
    tbl.push_back(mk("LH", T_RDH, 1, 32'h2002, 32'h0, 5'd9, 32'h8001_FFFF,
                     32'h2000, 4'b0000, 32'h0, 32'hFFFF_8001, 0));
    tbl.push_back(mk("LHU lo", T_RDH, 0, 32'h2000, 32'h0, 5'd10, 32'h8001_FFFF,
                     32'h2000, 4'b0000, 32'h0, 32'h0000_FFFF, 0));
    tbl.push_back(mk("LW", T_RDW, 1, 32'h2000, 32'h0, 5'd11, 32'h8001_FFFF,
                     32'h2000, 4'b0000, 32'h0, 32'h8001_FFFF, 0));
    tbl.push_back(mk("SH", T_WRH, 0, 32'h4002, 32'h1234_BEEF, 5'd2, 32'h0,
                     32'h4000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0));
    tbl.push_back(mk("SW", T_WRW, 0, 32'h5004, 32'hDEAD_BEEF, 5'd3, 32'h0,
                     32'h5004, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0));
    tbl.push_back(mk("LB lane1", T_RDB, 1, 32'h6001, 32'h0, 5'd12, 32'h0000_8000,
                     32'h6000, 4'b0000, 32'h0, 32'hFFFF_FF80, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk("LW mis", T_RDW, 0, 32'h3001, 32'h0, 5'd13, 32'hCAFE_F00D,
                     32'h3000, 4'b0000, 32'h0, 32'h0, 1));
    tbl.push_back(mk("LH mis", T_RDH, 0, 32'h3003, 32'h0, 5'd14, 32'hABCD_1234,
                     32'h3000, 4'b0000, 32'h0, 32'h0, 1));
`else
    tbl.push_back(mk("LW mis", T_RDW, 0, 32'h3001, 32'h0, 5'd13, 32'hCAFE_F00D,
                     32'h3000, 4'b0000, 32'h0, 32'hCAFE_F00D, 0));
    tbl.push_back(mk("LH mis", T_RDH, 0, 32'h3003, 32'h0, 5'd14, 32'hABCD_1234,
                     32'h3000, 4'b0000, 32'h0, 32'h0000_ABCD, 0));
`endif

    rst_n = 1'b0; ls_valid = 1'b0; ls_type = T_NONE; ls_sign_ext = 1'b0;
    ls_addr = '0; ls_wdata = '0; ls_rd = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1357_9BDF;
    tick(); tick();
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst done", 32'(ls_done), 32'd0);
    chk("rst stall", 32'(ls_stall), 32'd0);
    chk("rst wb_en", 32'(ls_wb_en), 32'd0);
    chk("rst err", 32'(ls_err), 32'd0);
    chk("rst rdata", ls_rdata, 32'd0);
    chk("rst wstrb", 32'(bus_wstrb), 32'd0);
    rst_n = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    #1 chk("stale rvalid after rst", 32'(ls_done), 32'd0);

    // Minimum-latency sweep over the table.
    foreach (tbl[i]) run(tbl[i], 0, 1, 1'b0);

    // Type NONE with ls_valid is ignored.
    ls_valid = 1'b1; ls_type = T_NONE; ls_addr = 32'h7000;
    #1 chk("NONE stall", 32'(ls_stall), 32'd0);
    tick();
    ls_valid = 1'b0;
    #1 chk("NONE req", 32'(bus_req), 32'd0);
    tick();
    chk("NONE done", 32'(ls_done), 32'd0);

    // Backpressure: gnt held low 3 cycles, rvalid 2 cycles after gnt.
    run(mk("BP SW", T_WRW, 0, 32'h8008, 32'h0BAD_F00D, 5'd4, 32'h0,
           32'h8008, 4'b1111, 32'h0BAD_F00D, 32'h0, 0), 3, 2, 1'b0);
    run(mk("BP LH", T_RDH, 1, 32'h8002, 32'h0, 5'd6, 32'h7FFF_0000,
           32'h8000, 4'b0000, 32'h0, 32'h0000_7FFF, 0), 3, 2, 1'b0);

    // ls_valid during DONE must not start a new access.
    run(mk("DONE poke", T_RDW, 0, 32'hA000, 32'h0, 5'd8, 32'h0102_0304,
           32'hA000, 4'b0000, 32'h0, 32'h0102_0304, 0), 0, 1, 1'b1);

    // Reset while in RSP, then a stale rvalid.
    ls_valid = 1'b1; ls_type = T_RDW; ls_addr = 32'hB000; ls_rd = 5'd15;
    tick();
    ls_valid = 1'b0; ls_type = T_NONE; bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    #1 chk("pre-rst in RSP stall", 32'(ls_stall), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst req", 32'(bus_req), 32'd0);
    chk("midrst done", 32'(ls_done), 32'd0);
    chk("midrst stall", 32'(ls_stall), 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
    tick();
    bus_rvalid = 1'b0;
    #1;
    chk("stale rvalid done", 32'(ls_done), 32'd0);
    chk("stale rvalid req", 32'(bus_req), 32'd0);
    tick();
    chk("stale rvalid done2", 32'(ls_done), 32'd0);
    run(mk("LW after rst", T_RDW, 0, 32'hC004, 32'h0, 5'd16, 32'h2468_ACE0,
           32'hC004, 4'b0000, 32'h0, 32'h2468_ACE0, 0), 0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
